// File: rtl/counter_load_sched.sv
// counter_load_sched: round-robin preload scheduler for a mod-(MAX_VAL+1)
// counter, with capture check and natural-wrap monitor.
module counter_load_sched #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 4,
    parameter int MAX_VAL = 13
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [DATA_W-1:0]          cnt_value,
    output logic                       cnt_load,
    output logic [DATA_W-1:0]          cnt_data,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       load_err,
    output logic                       mismatch,
    output logic                       wrap_pulse,
    output logic [7:0]                 wrap_count,
    input  logic                       wrap_clr
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam logic [DATA_W-1:0] MAXV = DATA_W'(MAX_VAL);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CHECK,
        REJECT
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     win_id;
    logic               win_found;
    logic [DATA_W-1:0]  win_data;
    logic [DATA_W-1:0]  prev_val;
    logic               wrap;
    logic [IDW-1:0]     rr_next;

    // Round-robin pick: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_id    = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                win_found = 1'b1;
                win_id    = IDW'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
        win_data = req_data[int'(win_id)*DATA_W +: DATA_W];
    end

    assign rr_next = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;

    // State register; reset drops cnt_load/req_ready at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and outputs decoded from the registered state only.
    always_comb begin
        state_d   = state_q;
        cnt_load  = 1'b0;
        load_err  = 1'b0;
        req_ready = '0;
        busy      = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (win_found)
                    state_d = (win_data > MAXV) ? REJECT : LOAD;
            end
            LOAD: begin
                cnt_load            = 1'b1;
                req_ready[grant_id] = 1'b1;
                state_d             = CHECK;
            end
            CHECK: begin
                state_d = IDLE;
            end
            REJECT: begin
                load_err            = 1'b1;
                req_ready[grant_id] = 1'b1;
                state_d             = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant capture, pointer advance and sticky capture check.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_id <= '0;
            cnt_data <= '0;
            rr_ptr   <= '0;
            mismatch <= 1'b0;
        end else begin
            if (state_q == IDLE && win_found) begin
                grant_id <= win_id;
                cnt_data <= win_data;
            end
            if (state_q == LOAD || state_q == REJECT)
                rr_ptr <= rr_next;
            if (state_q == CHECK && cnt_value != cnt_data)
                mismatch <= 1'b1;
        end
    end

    // A load landing on 0 shows up during CHECK, so it is excluded.
    assign wrap = (prev_val == MAXV) && (cnt_value == '0)
                  && (state_q != CHECK);

    // Wrap tracking; clear beats increment, count saturates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_val   <= '0;
            wrap_pulse <= 1'b0;
            wrap_count <= '0;
        end else begin
            prev_val   <= cnt_value;
            wrap_pulse <= wrap;
            if (wrap_clr)
                wrap_count <= '0;
            else if (wrap && wrap_count != 8'hFF)
                wrap_count <= wrap_count + 8'd1;
        end
    end

endmodule
